// File: rtl/drop_time_if.sv
// Handshake and data bundle between the drop-time calculator and its neighbours.
// The master drives the sample request. The slave returns status and the registered results.
interface drop_time_if #(
  parameter int ALT_W = 16
);
  logic             sample;
  logic [ALT_W-1:0] altitude;
  logic             zone_in;
  logic [15:0]      t_lim_in;
  logic             busy;
  logic             valid;
  logic [15:0]      t_act;
  logic [15:0]      t_lim;
  logic             drop_en;

  modport master (
    output sample, altitude, zone_in, t_lim_in,
    input  busy, valid, t_act, t_lim, drop_en
  );

  modport slave (
    input  sample, altitude, zone_in, t_lim_in,
    output busy, valid, t_act, t_lim, drop_en
  );
endinterface

// File: rtl/drop_time_calc.sv
// Fall-time calculator: t_act = floor(sqrt(altitude << ALT_SHIFT)), one root bit per cycle.
// Optional macro DROP_STALE_GUARD_EN forces drop_en/t_act safe after STALE_CYCLES without a result.
module drop_time_calc #(
  parameter int ALT_W        = 16,
  parameter int ALT_SHIFT    = 1,
  parameter int STALE_CYCLES = 1000
) (
  input  logic      clk,
  input  logic      rst,
  drop_time_if.slave bus
);

  localparam int N     = (ALT_W + ALT_SHIFT + 1) / 2;
  localparam int RAD_W = 2 * N;
  localparam int REM_W = N + 2;
  localparam int CNT_W = $clog2(N + 1);

  if (ALT_W + ALT_SHIFT > 32) begin : g_bad_width
    $error("drop_time_calc: ALT_W + ALT_SHIFT must not exceed 32");
  end
  if (STALE_CYCLES < 1) begin : g_bad_stale
    $error("drop_time_calc: STALE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [RAD_W-1:0]   rad_q, rad_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [N-1:0]       root_q, root_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               zone_sh_q, zone_sh_d;
  logic [15:0]        lim_sh_q, lim_sh_d;
  logic [15:0]        t_act_q, t_act_d;
  logic [15:0]        t_lim_q, t_lim_d;
  logic               drop_en_q, drop_en_d;
  logic               valid_q, valid_d;

  logic [RAD_W-1:0]   rad_in;
  logic [REM_W+1:0]   rem_sh;
  logic [REM_W+1:0]   sub_val;
  logic [REM_W+1:0]   diff;
  logic               ge;
  logic [15:0]        root_ext;

  // Restoring step: bring down the top radicand pair and try to subtract 4*root+1.
  always_comb begin
    rad_in                = '0;
    rad_in[ALT_W-1:0]     = bus.altitude;
    rad_in                = rad_in << ALT_SHIFT;
    rem_sh                = {rem_q, rad_q[RAD_W-1 -: 2]};
    sub_val               = '0;
    sub_val[REM_W-1:0]    = {root_q, 2'b01};
    diff                  = rem_sh - sub_val;
    ge                    = (rem_sh >= sub_val);
    root_ext              = '0;
    root_ext[N-1:0]       = root_q;
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rad_d     = rad_q;
    rem_d     = rem_q;
    root_d    = root_q;
    cnt_d     = cnt_q;
    zone_sh_d = zone_sh_q;
    lim_sh_d  = lim_sh_q;
    t_act_d   = t_act_q;
    t_lim_d   = t_lim_q;
    drop_en_d = drop_en_q;
    valid_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.sample) begin
          rad_d     = rad_in;
          zone_sh_d = bus.zone_in;
          lim_sh_d  = bus.t_lim_in;
          rem_d     = '0;
          root_d    = '0;
          cnt_d     = '0;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        rem_d  = ge ? diff[REM_W-1:0] : rem_sh[REM_W-1:0];
        root_d = {root_q[N-2:0], ge};
        rad_d  = rad_q << 2;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        t_act_d   = root_ext;
        t_lim_d   = lim_sh_q;
        drop_en_d = zone_sh_q;
        valid_d   = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: shadow and datapath registers are reset too; it costs little and keeps simulation free of X.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      cnt_q     <= '0;
      zone_sh_q <= 1'b0;
      lim_sh_q  <= '0;
      t_act_q   <= 16'hFFFF;
      t_lim_q   <= '0;
      drop_en_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rad_q     <= rad_d;
      rem_q     <= rem_d;
      root_q    <= root_d;
      cnt_q     <= cnt_d;
      zone_sh_q <= zone_sh_d;
      lim_sh_q  <= lim_sh_d;
      t_act_q   <= t_act_d;
      t_lim_q   <= t_lim_d;
      drop_en_q <= drop_en_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.busy  = (state_q != S_IDLE);
  assign bus.valid = valid_q;
  assign bus.t_lim = t_lim_q;

`ifdef DROP_STALE_GUARD_EN
  localparam int AGE_W = $clog2(STALE_CYCLES + 1);

  logic [AGE_W-1:0] age_q, age_d;
  logic             stale;

  // Age restarts at every result and saturates at the limit.
  always_comb begin
    age_d = age_q;
    if (state_q == S_DONE) begin
      age_d = '0;
    end else if (age_q != AGE_W'(STALE_CYCLES)) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  assign stale       = (age_q == AGE_W'(STALE_CYCLES));
  assign bus.t_act   = stale ? 16'hFFFF : t_act_q;
  assign bus.drop_en = drop_en_q & ~stale;
`else
  assign bus.t_act   = t_act_q;
  assign bus.drop_en = drop_en_q;
`endif

endmodule

// File: tb/tb_drop_time_calc.sv
// Directed bench for drop_time_calc; stale-guard checks follow DROP_STALE_GUARD_EN.
module tb_drop_time_calc;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  drop_time_if #(.ALT_W(16)) bus ();

  drop_time_calc #(
    .ALT_W       (16),
    .ALT_SHIFT   (1),
    .STALE_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic start_sample(input logic [15:0] alt, input logic zone, input logic [15:0] lim);
    @(negedge clk);
    bus.altitude = alt;
    bus.zone_in  = zone;
    bus.t_lim_in = lim;
    bus.sample   = 1'b1;
    @(negedge clk);
    bus.sample   = 1'b0;
  endtask

  task automatic wait_valid(output bit seen, output int busy_cnt);
    seen     = 1'b0;
    busy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic do_calc(input logic [15:0] alt, input logic zone, input logic [15:0] lim,
                         output bit seen, output int busy_cnt);
    start_sample(alt, zone, lim);
    wait_valid(seen, busy_cnt);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_t_act", int'(bus.t_act), 16'hFFFF);
    chk("reset_t_lim", int'(bus.t_lim), 0);
    chk("reset_drop_en", int'(bus.drop_en), 0);
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_busy", int'(bus.busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", int'(bus.busy), 0);
    chk("post_reset_valid", int'(bus.valid), 0);
  endtask

  task automatic test_basic;
    bit seen;
    int busy_cnt;
    do_calc(16'd50, 1'b1, 16'd12, seen, busy_cnt);
    chk("basic_valid_seen", int'(seen), 1);
    chk("basic_busy_cycles", busy_cnt, 10);
    chk("basic_t_act", int'(bus.t_act), 10);
    chk("basic_t_lim", int'(bus.t_lim), 12);
    chk("basic_drop_en", int'(bus.drop_en), 1);
    @(negedge clk);
    chk("basic_valid_pulse", int'(bus.valid), 0);
    chk("basic_hold_t_act", int'(bus.t_act), 10);
  endtask

  task automatic test_boundaries;
    logic [15:0] alts [3] = '{16'hFFFF, 16'd0, 16'd2};
    int          exps [3] = '{362, 0, 2};
    logic [15:0] lims [3] = '{16'd400, 16'd65535, 16'd3};
    logic        zones[3] = '{1'b0, 1'b1, 1'b0};
    bit seen;
    int busy_cnt;
    for (int i = 0; i < 3; i++) begin
      do_calc(alts[i], zones[i], lims[i], seen, busy_cnt);
      chk($sformatf("bound_seen_%0d", i), int'(seen), 1);
      chk($sformatf("bound_t_act_%0d", i), int'(bus.t_act), exps[i]);
      chk($sformatf("bound_t_lim_%0d", i), int'(bus.t_lim), int'(lims[i]));
      chk($sformatf("bound_drop_en_%0d", i), int'(bus.drop_en), int'(zones[i]));
    end
  endtask

  task automatic test_sweep;
    bit          seen;
    int          busy_cnt;
    logic [15:0] lim;
    for (int h = 0; h <= 2000; h++) begin
      lim = 16'(h) ^ 16'hA5A5;
      do_calc(16'(h), h[0], lim, seen, busy_cnt);
      chk($sformatf("sweep_t_act_h%0d", h), seen ? int'(bus.t_act) : -1, isqrt(2 * h));
      if (h % 97 == 0) begin
        chk($sformatf("sweep_t_lim_h%0d", h), int'(bus.t_lim), int'(lim));
        chk($sformatf("sweep_drop_en_h%0d", h), int'(bus.drop_en), h % 2);
      end
    end
  endtask

  task automatic test_ignored_sample;
    int vcount;
    int t_act_v, t_lim_v, drop_v;
    vcount  = 0;
    t_act_v = -1;
    t_lim_v = -1;
    drop_v  = -1;
    start_sample(16'd200, 1'b0, 16'd7);
    for (int k = 1; k <= 30; k++) begin
      bus.sample = (k == 3 || k == 7);
      if (k == 3 || k == 7) begin
        bus.altitude = 16'd9999;
        bus.zone_in  = 1'b1;
        bus.t_lim_in = 16'd999;
      end
      if (bus.valid === 1'b1) begin
        vcount++;
        t_act_v = int'(bus.t_act);
        t_lim_v = int'(bus.t_lim);
        drop_v  = int'(bus.drop_en);
      end
      @(negedge clk);
    end
    bus.sample = 1'b0;
    chk("ignored_valid_count", vcount, 1);
    chk("ignored_t_act", t_act_v, 20);
    chk("ignored_t_lim", t_lim_v, 7);
    chk("ignored_drop_en", drop_v, 0);
  endtask

  task automatic test_reset_abort;
    int vcount;
    start_sample(16'd50, 1'b1, 16'd12);
    repeat (4) @(negedge clk);
    chk("abort_busy_before", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_t_act", int'(bus.t_act), 16'hFFFF);
    chk("abort_t_lim", int'(bus.t_lim), 0);
    chk("abort_drop_en", int'(bus.drop_en), 0);
    vcount = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.valid === 1'b1) vcount++;
      @(negedge clk);
    end
    chk("abort_no_valid", vcount, 0);
  endtask

  task automatic test_back_to_back;
    bit seen;
    int busy_cnt;
    int gap;
    start_sample(16'd50, 1'b1, 16'd12);
    bus.sample = 1'b1;
    wait_valid(seen, busy_cnt);
    chk("b2b_first_seen", int'(seen), 1);
    chk("b2b_first_t_act", int'(bus.t_act), 10);
    gap = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      gap++;
      if (bus.valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("b2b_second_seen", int'(seen), 1);
    chk("b2b_gap", gap, 11);
    chk("b2b_second_t_act", int'(bus.t_act), 10);
    bus.sample = 1'b0;
    for (int k = 0; k < 40 && bus.busy === 1'b1; k++) @(negedge clk);
    chk("b2b_drain_busy", int'(bus.busy), 0);
  endtask

  task automatic test_stale;
    bit seen;
    int busy_cnt;
    do_calc(16'd50, 1'b1, 16'd12, seen, busy_cnt);
    chk("stale_setup_drop_en", int'(bus.drop_en), 1);
`ifdef DROP_STALE_GUARD_EN
    repeat (19) @(negedge clk);
    chk("stale_19_drop_en", int'(bus.drop_en), 1);
    chk("stale_19_t_act", int'(bus.t_act), 10);
    @(negedge clk);
    chk("stale_20_drop_en", int'(bus.drop_en), 0);
    chk("stale_20_t_act", int'(bus.t_act), 16'hFFFF);
    chk("stale_20_t_lim", int'(bus.t_lim), 12);
    do_calc(16'd50, 1'b1, 16'd12, seen, busy_cnt);
    chk("stale_restore_drop_en", int'(bus.drop_en), 1);
    chk("stale_restore_t_act", int'(bus.t_act), 10);
`else
    repeat (40) @(negedge clk);
    chk("hold_drop_en", int'(bus.drop_en), 1);
    chk("hold_t_act", int'(bus.t_act), 10);
    chk("hold_t_lim", int'(bus.t_lim), 12);
`endif
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.sample   = 1'b0;
    bus.altitude = '0;
    bus.zone_in  = 1'b0;
    bus.t_lim_in = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_sweep();
    test_ignored_sample();
    test_reset_abort();
    test_back_to_back();
    test_stale();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
